// File: rtl/cp0_regs.sv
// System-coprocessor register file: commits exceptions into Status/Cause/EPC/BadVAddr,
// services MTC0/MFC0, clears EXL on ERET and runs the Count/Compare timer.
module cp0_regs #(
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = 32'h0000_0002
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        E_ENTER,
  input  logic [4:0]  CAUSE_IN,
  input  logic [31:0] EPC_IN,
  input  logic        BD_IN,
  input  logic        BADVA_WE,
  input  logic [31:0] BADVA_IN,
  input  logic        ERET,
  input  logic        WE,
  input  logic [4:0]  WADDR,
  input  logic [31:0] WDATA,
  input  logic [4:0]  RADDR,
  output logic [31:0] RDATA,
  output logic [31:0] EPC_OUT,
  output logic        EXL_OUT,
  output logic        INT_COUNTER
);

  localparam logic [4:0] PRESC_MAX = 5'(COUNT_DIV - 1);

  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic        cause_bd;
  logic        cause_ip7;
  logic [1:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;
  logic [31:0] badva;
  logic [31:0] count;
  logic [31:0] compare;
  logic [4:0]  presc;

  logic        wr;
  logic        wr_count;
  logic        wr_compare;
  logic        tick;
  logic [31:0] count_inc;
  logic        match;

  // A squashed instruction (E_ENTER) or a committing ERET drops the MTC0 entirely.
  assign wr         = WE & ~E_ENTER & ~ERET;
  assign wr_count   = wr & (WADDR == 5'd9);
  assign wr_compare = wr & (WADDR == 5'd11);
  assign tick       = (presc == PRESC_MAX);
  assign count_inc  = count + 32'd1;
  assign match      = tick & ~wr_count & (count_inc == compare);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      status_ie  <= STATUS_RST[0];
      status_exl <= STATUS_RST[1];
      status_im  <= STATUS_RST[15:8];
      cause_bd   <= 1'b0;
      cause_ip7  <= 1'b0;
      cause_ip   <= 2'b00;
      cause_exc  <= 5'd0;
      epc        <= 32'd0;
      badva      <= 32'd0;
      count      <= 32'd0;
      compare    <= 32'd0;
      presc      <= 5'd0;
    end else begin
      if (wr_count) begin
        count <= WDATA;
        presc <= 5'd0;
      end else begin
        presc <= tick ? 5'd0 : presc + 5'd1;
        if (tick) count <= count_inc;
      end

      // Compare write clears IP7 even when a match lands in the same cycle.
      if (wr_compare) begin
        compare   <= WDATA;
        cause_ip7 <= 1'b0;
      end else if (match) begin
        cause_ip7 <= 1'b1;
      end

      if (E_ENTER) begin
        cause_exc  <= CAUSE_IN;
        status_exl <= 1'b1;
        if (!status_exl) begin
          epc      <= EPC_IN;
          cause_bd <= BD_IN;
        end
        if (BADVA_WE) badva <= BADVA_IN;
      end else if (ERET) begin
        status_exl <= 1'b0;
      end else if (wr) begin
        case (WADDR)
          5'd12: begin
            status_ie  <= WDATA[0];
            status_exl <= WDATA[1];
            status_im  <= WDATA[15:8];
          end
          5'd13:   cause_ip <= WDATA[9:8];
          5'd14:   epc      <= WDATA;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    RDATA = 32'd0;
    case (RADDR)
      5'd8:  RDATA = badva;
      5'd9:  RDATA = count;
      5'd11: RDATA = compare;
      5'd12: RDATA = {16'd0, status_im, 6'd0, status_exl, status_ie};
      5'd13: RDATA = {cause_bd, 15'd0, cause_ip7, 5'd0, cause_ip, 1'b0, cause_exc, 2'b00};
      5'd14: RDATA = epc;
      default: RDATA = 32'd0;
    endcase
  end

  assign EPC_OUT     = epc;
  assign EXL_OUT     = status_exl;
  assign INT_COUNTER = cause_ip7 & status_im[7] & status_ie & ~status_exl;

endmodule

// File: tb/tb_cp0_regs.sv
// Bench for cp0_regs: directed scenarios plus random traffic, all checked against a
// word-array model of the register map updated once per clock edge.
module tb_cp0_regs;

  localparam int DIV = 2;
  localparam logic [31:0] SR_RST = 32'h0000_0002;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        E_ENTER = 1'b0;
  logic [4:0]  CAUSE_IN = '0;
  logic [31:0] EPC_IN = '0;
  logic        BD_IN = 1'b0;
  logic        BADVA_WE = 1'b0;
  logic [31:0] BADVA_IN = '0;
  logic        ERET = 1'b0;
  logic        WE = 1'b0;
  logic [4:0]  WADDR = '0;
  logic [31:0] WDATA = '0;
  logic [4:0]  RADDR = '0;
  logic [31:0] RDATA;
  logic [31:0] EPC_OUT;
  logic        EXL_OUT;
  logic        INT_COUNTER;

  cp0_regs #(.COUNT_DIV(DIV), .STATUS_RST(SR_RST)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .E_ENTER(E_ENTER), .CAUSE_IN(CAUSE_IN),
    .EPC_IN(EPC_IN), .BD_IN(BD_IN), .BADVA_WE(BADVA_WE), .BADVA_IN(BADVA_IN),
    .ERET(ERET), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .RADDR(RADDR),
    .RDATA(RDATA), .EPC_OUT(EPC_OUT), .EXL_OUT(EXL_OUT), .INT_COUNTER(INT_COUNTER)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: one 32-bit word per CP0 register number.
  logic [31:0] m_reg [32];
  int          m_phase;

  function automatic logic [31:0] wmask(input int a);
    case (a)
      9, 11, 14: return 32'hFFFF_FFFF;
      12:        return 32'h0000_FF03;
      13:        return 32'h0000_0300;
      default:   return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_reg[12] = SR_RST & 32'h0000_FF03;
    m_phase = 0;
  endtask

  function automatic logic m_int();
    return m_reg[13][15] & m_reg[12][15] & m_reg[12][0] & ~m_reg[12][1];
  endfunction

  task automatic model_step();
    logic [31:0] old [32];
    bit we_eff;
    int a;
    old = m_reg;
    a = int'(WADDR);
    we_eff = WE && !E_ENTER && !ERET;
    if (we_eff && a == 9) begin
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == DIV) begin
        m_phase = 0;
        m_reg[9] = old[9] + 32'd1;
        if (m_reg[9] == old[11]) m_reg[13][15] = 1'b1;
      end
    end
    if (we_eff && a == 11) m_reg[13][15] = 1'b0;
    if (E_ENTER) begin
      m_reg[13][6:2] = CAUSE_IN;
      m_reg[12][1] = 1'b1;
      if (!old[12][1]) begin
        m_reg[14] = EPC_IN;
        m_reg[13][31] = BD_IN;
      end
      if (BADVA_WE) m_reg[8] = BADVA_IN;
    end else if (ERET) begin
      m_reg[12][1] = 1'b0;
    end else if (WE) begin
      m_reg[a] = (m_reg[a] & ~wmask(a)) | (WDATA & wmask(a));
    end
  endtask

  task automatic idle();
    E_ENTER = 0; ERET = 0; WE = 0; BADVA_WE = 0; BD_IN = 0;
  endtask

  // One clock: compare all outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic [4:0] ra;
    @(negedge CLK);
    ra = 5'($urandom_range(0, 31));
    RADDR = ra;
    #1;
    check_eq($sformatf("rdata[%0d]", ra), RDATA, m_reg[int'(ra)]);
    check_eq("epc_out", EPC_OUT, m_reg[14]);
    check_eq("exl_out", {31'd0, EXL_OUT}, {31'd0, m_reg[12][1]});
    check_eq("int_counter", {31'd0, INT_COUNTER}, {31'd0, m_int()});
    @(posedge CLK);
    model_step();
    #1;
    idle();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    WE = 1; WADDR = a; WDATA = d;
    cycle();
  endtask

  task automatic exc(input logic [4:0] c, input logic [31:0] pc, input logic bd);
    E_ENTER = 1; CAUSE_IN = c; EPC_IN = pc; BD_IN = bd;
    cycle();
  endtask

  task automatic peek(input logic [4:0] a, output logic [31:0] d);
    RADDR = a;
    #1;
    d = RDATA;
  endtask

  initial begin
    logic [31:0] v;
    int n;
    model_reset();
    #12;
    peek(5'd12, v); check_eq("rst_status", v, 32'h0000_0002);
    check_eq("rst_exl", {31'd0, EXL_OUT}, 32'd1);
    check_eq("rst_epc", EPC_OUT, 32'd0);
    peek(5'd9, v); check_eq("rst_count", v, 32'd0);
    @(negedge CLK);
    RESET_N = 1;
    @(posedge CLK);
    model_step();
    #1;

    // Timer match and interrupt
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    n = 0;
    v = 0;
    while (n < 20 && v != 32'd5) begin
      cycle();
      n++;
      peek(5'd9, v);
    end
    check_eq("timer_latency", n, 32'd10);
    peek(5'd13, v); check_eq("timer_ip7", v & 32'h8000, 32'h8000);
    check_eq("timer_int", {31'd0, INT_COUNTER}, 32'd1);
    mtc0(5'd11, 32'd9);
    peek(5'd13, v); check_eq("cmp_clr_ip7", v & 32'h8000, 32'h0);
    check_eq("cmp_clr_int", {31'd0, INT_COUNTER}, 32'd0);

    // Nested exceptions
    exc(5'd8, 32'h8000_1000, 1'b1);
    check_eq("nest1_epc", EPC_OUT, 32'h8000_1000);
    peek(5'd13, v); check_eq("nest1_cause", v, 32'h8000_0020);
    exc(5'd12, 32'h8000_2000, 1'b0);
    check_eq("nest2_epc", EPC_OUT, 32'h8000_1000);
    peek(5'd13, v); check_eq("nest2_cause", v, 32'h8000_0030);
    ERET = 1; cycle();
    check_eq("eret_exl", {31'd0, EXL_OUT}, 32'd0);

    // E_ENTER + WE + ERET together
    E_ENTER = 1; CAUSE_IN = 5'd4; EPC_IN = 32'h8000_3000; ERET = 1;
    WE = 1; WADDR = 5'd14; WDATA = 32'hDEAD_0000;
    cycle();
    check_eq("simul_epc", EPC_OUT, 32'h8000_3000);
    check_eq("simul_exl", {31'd0, EXL_OUT}, 32'd1);

    // Count wrap and Count write equal to Compare
    mtc0(5'd11, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    n = 0;
    v = 32'hFFFF_FFFF;
    while (n < 10 && v != 32'd0) begin
      cycle();
      n++;
      peek(5'd9, v);
    end
    check_eq("wrap_count", v, 32'd0);
    peek(5'd13, v); check_eq("wrap_ip7", v & 32'h8000, 32'h8000);
    mtc0(5'd11, 32'h40);
    mtc0(5'd9, 32'h40);
    peek(5'd13, v); check_eq("cnt_eq_cmp_ip7", v & 32'h8000, 32'h0);
    cycle(); cycle();
    peek(5'd13, v); check_eq("cnt_eq_cmp_ip7_b", v & 32'h8000, 32'h0);

    // Map holes and BadVAddr
    peek(5'd3, v); check_eq("reg3_zero", v, 32'h0);
    mtc0(5'd12, 32'hFFFF_FFFF);
    peek(5'd12, v); check_eq("status_holes", v, 32'h0000_FF03);
    BADVA_WE = 1; BADVA_IN = 32'h1234;
    exc(5'd4, 32'h8000_4000, 1'b0);
    peek(5'd8, v); check_eq("badva_cap", v, 32'h1234);
    mtc0(5'd8, 32'hFFFF_FFFF);
    peek(5'd8, v); check_eq("badva_ro", v, 32'h1234);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      int sel;
      E_ENTER  = ($urandom_range(0, 9) == 0);
      ERET     = ($urandom_range(0, 9) == 0);
      WE       = ($urandom_range(0, 2) == 0);
      CAUSE_IN = 5'($urandom());
      EPC_IN   = $urandom();
      BD_IN    = 1'($urandom());
      BADVA_WE = 1'($urandom());
      BADVA_IN = $urandom();
      WDATA    = $urandom();
      sel = $urandom_range(0, 7);
      case (sel)
        0: WADDR = 5'd8;
        1: begin WADDR = 5'd9; WDATA = m_reg[11] - 32'($urandom_range(0, 4)); end
        2: WADDR = 5'd11;
        3: begin WADDR = 5'd12; WDATA = (WDATA & ~32'h2) | 32'h8001; end
        4: WADDR = 5'd13;
        5: WADDR = 5'd14;
        default: WADDR = 5'($urandom());
      endcase
      cycle();
    end

    // Asynchronous reset mid-run
    mtc0(5'd9, 32'h123);
    WE = 1; WADDR = 5'd14; WDATA = 32'h5555_0000;
    #2;
    RESET_N = 0;
    model_reset();
    peek(5'd9, v); check_eq("arst_count", v, 32'd0);
    check_eq("arst_exl", {31'd0, EXL_OUT}, 32'd1);
    check_eq("arst_epc", EPC_OUT, 32'd0);
    check_eq("arst_int", {31'd0, INT_COUNTER}, 32'd0);
    peek(5'd12, v); check_eq("arst_status", v, 32'h0000_0002);
    idle();
    RESET_N = 1;
    for (int i = 0; i < 8; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
